pong_match_controller: RTL
==========================

Name: pong_match_controller

Overview:
Match-level sequencer for the Pong game. It gates paddle and ball motion (run), requests ball re-centering, counts points from miss pulses raised by the ball logic, and declares the winner. It sits between the FPGA keys and the img_generator datapath. All outputs are registered.

Parameters:
WIN_SCORE, 9, points needed to win a match; legal range 1..15.
SERVE_DELAY_TICKS, 60, frame_tick count spent frozen before each serve; legal range 1..255.
POINT_HOLD_TICKS, 30, frame_tick count spent frozen after a point; legal range 1..255.

Ports:
CLOCK_25  in  1  system clock, 25 MHz
RESET_N  in  1  reset; asynchronous assert, active-low
frame_tick  in  1  one-cycle pulse per ball step (BALL_CLOCK rate)
key_pause_n  in  1  raw FPGA key, active-low, asynchronous
key_continue_n  in  1  raw FPGA key, active-low, asynchronous
miss_p1  in  1  one-cycle pulse: player 1 missed, so player 2 scores
miss_p2  in  1  one-cycle pulse: player 2 missed, so player 1 scores
run  out  1  1 = datapath may move the ball and paddles
ball_reset  out  1  one-cycle pulse: re-center the ball
serve_left  out  1  serve direction; 1 = ball travels toward player 1
score_p1  out  4  player 1 score
score_p2  out  4  player 2 score
winner_color  out  3  001 = player 1 won, 100 = player 2 won, 000 = no winner yet
state  out  3  IDLE=0, SERVE=1, PLAY=2, PAUSED=3, POINT=4, GAME_OVER=5

Behaviour:
- Reset (RESET_N low, any time, including mid-match): state=IDLE, run=0, ball_reset=0, serve_left=0, scores=0, winner_color=000, tick counter=0, key synchronisers set to 1 (released). The reset clears everything immediately, without waiting for a clock edge.
- Key handling:
  - Each key passes through a 2-flop synchroniser plus one history flop.
  - A press is a 1->0 transition of the synchronised value.
  - A key low at setup before edge k acts on the state at edge k+3.
  - Holding a key low produces one press only.
- run=1 only in PLAY.
- The tick counter decrements only on cycles with frame_tick=1.
- IDLE:
  - continue press -> SERVE.
  - On that transition: scores<=0, winner<=000, counter<=SERVE_DELAY_TICKS, ball_reset pulses.
  - pause press is ignored.
- SERVE:
  - When frame_tick=1 and counter==1 -> PLAY.
  - Otherwise, counter decrements on each frame_tick.
  - Keys and miss pulses are ignored.
- PLAY:
  - miss_p1 alone: score_p2+1, serve_left<=1, -> POINT.
  - miss_p2 alone: score_p1+1, serve_left<=0, -> POINT.
  - miss_p1 and miss_p2 in the same cycle: no score change, serve_left unchanged, -> POINT.
  - On every entry to POINT: counter<=POINT_HOLD_TICKS.
  - A miss has priority over a pause press in the same cycle.
  - pause press alone -> PAUSED.
- PAUSED:
  - continue press -> PLAY.
  - Miss pulses are ignored.
  - The counter holds its value.
- POINT:
  - Counting and expiry (frame_tick=1 with counter==1) follow SERVE.
  - On expiry, if score_p1==WIN_SCORE: winner<=001, -> GAME_OVER.
  - Else if score_p2==WIN_SCORE: winner<=100, -> GAME_OVER.
  - Else: counter<=SERVE_DELAY_TICKS, ball_reset pulses, -> SERVE.
- GAME_OVER:
  - run=0; scores and winner are held.
  - continue press -> IDLE; scores and winner are kept until the next IDLE->SERVE transition.
- Scores are 4-bit and cannot exceed WIN_SCORE, because play stops at WIN_SCORE. No wrap logic is needed.
- ball_reset is high only for the single cycle after a transition into SERVE.
- state and all other outputs change on the same edge as the state transition.

Test Plan:
1. Reset mid-PLAY with score_p1=3: drop RESET_N between clock edges -> state=0, run=0, scores=0 with no clock edge needed.
2. Continue press from IDLE with SERVE_DELAY_TICKS=4 -> 3 edges later state=1, ball_reset high for 1 cycle; after 4 frame_ticks state=2, run=1.
3. miss_p2 in PLAY -> score_p1=1, serve_left=0, state=4; after 30 ticks, state=1 with a ball_reset pulse. miss_p1 and miss_p2 together -> scores unchanged, state=4.
4. Pause press in PLAY -> state=3, run=0; a miss_p1 pulse while paused -> no score change; continue press -> state=2.
5. WIN_SCORE=2, two miss_p1 pulses, each played through POINT and SERVE back to PLAY -> score_p2=2, then after POINT hold winner_color=100, state=5. Continue press -> state=0 with score_p2 still 2; next continue -> scores 0.
6. Key held low for 1000 cycles in PLAY -> exactly one PAUSED transition. A pause press and a miss in the same cycle -> state=4.

Source files
------------

// File: rtl/pong_match_controller.sv
// Pong match sequencer: synchronises the two keys, times the serve and point
// holds, counts points from miss pulses and declares the winner. Every output is a register.
module pong_match_controller #(
   parameter int WIN_SCORE         = 9,
   parameter int SERVE_DELAY_TICKS = 60,
   parameter int POINT_HOLD_TICKS  = 30
) (
   input  logic       CLOCK_25,
   input  logic       RESET_N,
   input  logic       frame_tick,
   input  logic       key_pause_n,
   input  logic       key_continue_n,
   input  logic       miss_p1,
   input  logic       miss_p2,
   output logic       run,
   output logic       ball_reset,
   output logic       serve_left,
   output logic [3:0] score_p1,
   output logic [3:0] score_p2,
   output logic [2:0] winner_color,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SERVE     = 3'd1,
      S_PLAY      = 3'd2,
      S_PAUSED    = 3'd3,
      S_POINT     = 3'd4,
      S_GAME_OVER = 3'd5
   } state_t;

   localparam logic [3:0] WIN        = 4'(WIN_SCORE);
   localparam logic [7:0] SERVE_LOAD = 8'(SERVE_DELAY_TICKS);
   localparam logic [7:0] HOLD_LOAD  = 8'(POINT_HOLD_TICKS);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] p1_d, p2_d;
   logic [2:0] winner_d;
   logic       serve_left_d, ball_reset_d;

   logic [1:0] pause_sync, cont_sync;
   logic       pause_hist, cont_hist;
   logic       pause_press, cont_press;

   // The press strobe is registered, so a key low before edge k acts at edge k+3.
   always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
      if (!RESET_N) begin
         pause_sync  <= 2'b11;
         cont_sync   <= 2'b11;
         pause_hist  <= 1'b1;
         cont_hist   <= 1'b1;
         pause_press <= 1'b0;
         cont_press  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the pre-edge value.
         pause_sync  <= {pause_sync[0], key_pause_n};
         cont_sync   <= {cont_sync[0], key_continue_n};
         pause_hist  <= pause_sync[1];
         cont_hist   <= cont_sync[1];
         pause_press <= pause_hist & ~pause_sync[1];
         cont_press  <= cont_hist & ~cont_sync[1];
      end
   end

   always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         score_p1     <= '0;
         score_p2     <= '0;
         winner_color <= '0;
         serve_left   <= 1'b0;
         ball_reset   <= 1'b0;
         run          <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         score_p1     <= p1_d;
         score_p2     <= p2_d;
         winner_color <= winner_d;
         serve_left   <= serve_left_d;
         ball_reset   <= ball_reset_d;
         run          <= (state_d == S_PLAY);
      end
   end

   assign state = state_q;

   always_comb begin
      // NOTE: every target gets a default first, so no path can infer a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      p1_d         = score_p1;
      p2_d         = score_p2;
      winner_d     = winner_color;
      serve_left_d = serve_left;
      ball_reset_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cont_press) begin
               state_d      = S_SERVE;
               p1_d         = '0;
               p2_d         = '0;
               winner_d     = '0;
               cnt_d        = SERVE_LOAD;
               ball_reset_d = 1'b1;
            end
         end
         S_SERVE: begin
            if (frame_tick) begin
               if (cnt_q == 8'd1) state_d = S_PLAY;
               else               cnt_d   = cnt_q - 8'd1;
            end
         end
         S_PLAY: begin
            if (miss_p1 || miss_p2) begin
               state_d = S_POINT;
               cnt_d   = HOLD_LOAD;
               if (miss_p1 && !miss_p2) begin
                  p2_d         = score_p2 + 4'd1;
                  serve_left_d = 1'b1;
               end else if (miss_p2 && !miss_p1) begin
                  p1_d         = score_p1 + 4'd1;
                  serve_left_d = 1'b0;
               end
            end else if (pause_press) begin
               state_d = S_PAUSED;
            end
         end
         S_PAUSED: begin
            if (cont_press) state_d = S_PLAY;
         end
         S_POINT: begin
            if (frame_tick) begin
               if (cnt_q == 8'd1) begin
                  if (score_p1 == WIN) begin
                     winner_d = 3'b001;
                     state_d  = S_GAME_OVER;
                  end else if (score_p2 == WIN) begin
                     winner_d = 3'b100;
                     state_d  = S_GAME_OVER;
                  end else begin
                     cnt_d        = SERVE_LOAD;
                     ball_reset_d = 1'b1;
                     state_d      = S_SERVE;
                  end
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         S_GAME_OVER: begin
            if (cont_press) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
